wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Write-back end of the MEM-stage result interface.
- Registers the MEM outputs (GPR write enable/address/data, HI/LO write enable/values) into a MEM/WB stage register with stall and flush control.
- Commits the registered results into the 32-entry general-purpose register file and the HI/LO registers.
- Serves two combinational GPR read ports and a HI/LO read port to decode/execute, with write-back bypass.

Parameters:
DATA_W, 32, width of GPRs, HI, LO
ADDR_W, 5, GPR address width (2**ADDR_W entries)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_stall  in  1  hold MEM/WB register contents
i_flush  in  1  load bubble into MEM/WB register; priority over i_stall
i_wen  in  1  GPR write enable from MEM
i_waddr  in  ADDR_W  GPR write address from MEM
i_wdata  in  DATA_W  GPR write data from MEM
i_hilo_wen  in  1  HI/LO write enable from MEM
i_hi  in  DATA_W  HI value from MEM
i_lo  in  DATA_W  LO value from MEM
i_ren1  in  1  read port 1 enable
i_raddr1  in  ADDR_W  read port 1 address
o_rdata1  out  DATA_W  read port 1 data
i_ren2  in  1  read port 2 enable
i_raddr2  in  ADDR_W  read port 2 address
o_rdata2  out  DATA_W  read port 2 data
o_hi  out  DATA_W  current HI, bypassed
o_lo  out  DATA_W  current LO, bypassed
o_wb_wen  out  1  registered write-back enable, for ID forwarding
o_wb_waddr  out  ADDR_W  registered write-back address
o_wb_wdata  out  DATA_W  registered write-back data

Behaviour:
Reset:
- i_rst_n low asynchronously clears the following to 0: MEM/WB register (wb_wen, wb_waddr, wb_wdata, wb_hilo_wen, wb_hi, wb_lo), all GPRs, HI, LO.
- Outputs therefore read 0 during reset.
- Reset mid-operation discards any uncommitted MEM/WB contents.

MEM/WB register, updated each rising edge, priority order:
- i_flush=1: load a bubble (all fields 0).
- else i_stall=1: hold all fields.
- else: capture the i_* MEM inputs.
- Latency from MEM inputs to o_wb_*: 1 cycle.

Commit, same rising edge, using the current (pre-update) MEM/WB contents:
- wb_wen=1 and wb_waddr!=0: gpr[wb_waddr] <= wb_wdata.
- wb_hilo_wen=1: HI <= wb_hi and LO <= wb_lo together.
- Commit proceeds while stalled; rewriting the same value is idempotent.
- Flush does not cancel the commit of the entry leaving MEM/WB on that edge.
- Total latency from MEM input to architectural state: 2 edges.

GPR read ports (combinational, each port independent), priority:
- ren=0: output 0.
- raddr=0: output 0 (r0 hard-wired zero, never written).
- wb_wen=1 and wb_waddr==raddr: output wb_wdata (bypass of the pending commit).
- otherwise: output gpr[raddr].
- Both ports on the same address return identical data.

HI/LO read:
- wb_hilo_wen=1: o_hi=wb_hi, o_lo=wb_lo.
- otherwise: the HI and LO registers.

o_wb_* are direct copies of wb_wen, wb_waddr and wb_wdata.

No arithmetic. Addresses are used at full ADDR_W with no wrap.

Test Plan:
1. Reset then idle: all reads, o_hi, o_lo and o_wb_* are 0. Assert i_rst_n low mid-write (wen=1, waddr=3, wdata=0xDEADBEEF captured, not yet committed) -> gpr[3] reads 0 after release.
2. Write and bypass:
   - Drive wen=1, waddr=5, wdata=0x12345678 for one cycle.
   - Next cycle: o_wb_wen=1; raddr1=5, ren1=1 -> 0x12345678 via bypass.
   - Following cycle with inputs idle: still 0x12345678, now from the GPR.
3. r0 protection:
   - Write waddr=0, wdata=0xFFFFFFFF.
   - raddr1=0 reads 0 in the bypass cycle and afterwards; o_wb_wen=1, o_wb_waddr=0 are still visible.
4. HI/LO:
   - Drive hilo_wen=1, hi=0xAAAA0000, lo=0x0000BBBB.
   - Next cycle: o_hi and o_lo show these values via bypass, and keep them after the commit.
   - A later hilo_wen=0 cycle leaves them unchanged.
5. Stall and flush:
   - Capture waddr=7, wdata=1.
   - Stall 3 cycles while inputs change to waddr=8, wdata=2: o_wb_* hold 7/1 and gpr[8] stays 0.
   - Assert flush and stall together: o_wb_wen=0 next cycle; gpr[7]=1 committed; gpr[8]=0.
6. Read enables and dual port:
   - ren2=0 with raddr2=7 -> 0.
   - ren1=ren2=1, raddr1=raddr2=7 -> both 1.
   - Back-to-back writes to 9 (values 3 then 4): reads follow 3 then 4 with no stale cycle.

Source files
------------

// File: rtl/wb_regfile_if.sv
// MEM-to-WB result bus plus the decode/execute read ports of the register file.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  // MEM/WB control and MEM results
  logic              i_stall;
  logic              i_flush;
  logic              i_wen;
  logic [ADDR_W-1:0] i_waddr;
  logic [DATA_W-1:0] i_wdata;
  logic              i_hilo_wen;
  logic [DATA_W-1:0] i_hi;
  logic [DATA_W-1:0] i_lo;
  // GPR read ports
  logic              i_ren1;
  logic [ADDR_W-1:0] i_raddr1;
  logic [DATA_W-1:0] o_rdata1;
  logic              i_ren2;
  logic [ADDR_W-1:0] i_raddr2;
  logic [DATA_W-1:0] o_rdata2;
  // HI/LO read and write-back forwarding
  logic [DATA_W-1:0] o_hi;
  logic [DATA_W-1:0] o_lo;
  logic              o_wb_wen;
  logic [ADDR_W-1:0] o_wb_waddr;
  logic [DATA_W-1:0] o_wb_wdata;

  modport master (
    output i_stall, i_flush, i_wen, i_waddr, i_wdata, i_hilo_wen, i_hi, i_lo,
    output i_ren1, i_raddr1, i_ren2, i_raddr2,
    input  o_rdata1, o_rdata2, o_hi, o_lo, o_wb_wen, o_wb_waddr, o_wb_wdata
  );

  modport slave (
    input  i_stall, i_flush, i_wen, i_waddr, i_wdata, i_hilo_wen, i_hi, i_lo,
    input  i_ren1, i_raddr1, i_ren2, i_raddr2,
    output o_rdata1, o_rdata2, o_hi, o_lo, o_wb_wen, o_wb_waddr, o_wb_wdata
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage: MEM/WB pipeline register, GPR file and HI/LO commit,
// with combinational read ports that bypass the pending commit.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic         i_clk,
  input logic         i_rst_n,
  wb_regfile_if.slave bus
);
  localparam int NREGS = 2 ** ADDR_W;

  typedef struct packed {
    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              hilo_wen;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } wb_t;

  wb_t               wb;
  wb_t               mem_in;
  logic [DATA_W-1:0] gpr [NREGS];
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  assign mem_in = '{wen: bus.i_wen, waddr: bus.i_waddr, wdata: bus.i_wdata,
                    hilo_wen: bus.i_hilo_wen, hi: bus.i_hi, lo: bus.i_lo};

  // MEM/WB register: flush beats stall, otherwise capture MEM results
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)         wb <= '0;
    else if (bus.i_flush) wb <= '0;
    else if (!bus.i_stall) wb <= mem_in;
  end

  // GPR commit from the entry currently in MEM/WB; r0 is never written
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREGS; i++) gpr[i] <= '0;
    end else if (wb.wen && (wb.waddr != '0)) begin
      gpr[wb.waddr] <= wb.wdata;
    end
  end

  // HI/LO commit, both halves together
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (wb.hilo_wen) begin
      hi_q <= wb.hi;
      lo_q <= wb.lo;
    end
  end

  // One GPR read port: disabled and r0 read zero, pending commit wins over the array
  function automatic logic [DATA_W-1:0] rd_port(input logic ren, input logic [ADDR_W-1:0] raddr);
    if (!ren || raddr == '0)              return '0;
    if (wb.wen && wb.waddr == raddr)      return wb.wdata;
    return gpr[raddr];
  endfunction

  // Read ports and HI/LO view, bypassing the not-yet-committed entry
  always_comb begin
    bus.o_rdata1 = rd_port(bus.i_ren1, bus.i_raddr1);
    bus.o_rdata2 = rd_port(bus.i_ren2, bus.i_raddr2);
    bus.o_hi     = wb.hilo_wen ? wb.hi : hi_q;
    bus.o_lo     = wb.hilo_wen ? wb.lo : lo_q;
  end

  assign bus.o_wb_wen   = wb.wen;
  assign bus.o_wb_waddr = wb.waddr;
  assign bus.o_wb_wdata = wb.wdata;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed plus randomized bench for wb_regfile against an architectural model:
// "arch" holds committed state, "pend" the one result waiting to commit.
module tb_wb_regfile;
  localparam int DW = 32;
  localparam int AW = 5;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  wb_regfile_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  wb_regfile #(.DATA_W(DW), .ADDR_W(AW)) dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus));

  int n_pass = 0;
  int n_total = 0;

  // reference model
  logic [DW-1:0] arch_gpr [32];
  logic [DW-1:0] arch_hi, arch_lo;
  logic          pend_wen, pend_hwen;
  logic [AW-1:0] pend_waddr;
  logic [DW-1:0] pend_wdata, pend_hi, pend_lo;

  task automatic m_reset();
    for (int i = 0; i < 32; i++) arch_gpr[i] = '0;
    arch_hi = '0; arch_lo = '0;
    pend_wen = 0; pend_hwen = 0; pend_waddr = '0;
    pend_wdata = '0; pend_hi = '0; pend_lo = '0;
  endtask

  // one clock edge: retire the pending result, then refill from MEM inputs
  task automatic m_edge();
    if (pend_wen && pend_waddr != 0) arch_gpr[pend_waddr] = pend_wdata;
    if (pend_hwen) begin arch_hi = pend_hi; arch_lo = pend_lo; end
    if (bus.i_flush) begin
      pend_wen = 0; pend_hwen = 0; pend_waddr = '0;
      pend_wdata = '0; pend_hi = '0; pend_lo = '0;
    end else if (!bus.i_stall) begin
      pend_wen = bus.i_wen; pend_waddr = bus.i_waddr; pend_wdata = bus.i_wdata;
      pend_hwen = bus.i_hilo_wen; pend_hi = bus.i_hi; pend_lo = bus.i_lo;
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic ren, input logic [AW-1:0] a);
    if (!ren || a == 0) return '0;
    if (pend_wen && pend_waddr == a) return pend_wdata;
    return arch_gpr[a];
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rdata1"}, bus.o_rdata1, exp_rd(bus.i_ren1, bus.i_raddr1));
    check({tag, ".rdata2"}, bus.o_rdata2, exp_rd(bus.i_ren2, bus.i_raddr2));
    check({tag, ".hi"}, bus.o_hi, pend_hwen ? pend_hi : arch_hi);
    check({tag, ".lo"}, bus.o_lo, pend_hwen ? pend_lo : arch_lo);
    check({tag, ".wb_wen"}, {31'd0, bus.o_wb_wen}, {31'd0, pend_wen});
    check({tag, ".wb_waddr"}, {27'd0, bus.o_wb_waddr}, {27'd0, pend_waddr});
    check({tag, ".wb_wdata"}, bus.o_wb_wdata, pend_wdata);
  endtask

  task automatic tick(input string tag);
    m_edge();
    @(posedge i_clk);
    #1;
    check_all(tag);
  endtask

  task automatic settle(input string tag);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    bus.i_stall = 0; bus.i_flush = 0; bus.i_wen = 0; bus.i_waddr = '0; bus.i_wdata = '0;
    bus.i_hilo_wen = 0; bus.i_hi = '0; bus.i_lo = '0;
  endtask

  initial begin
    idle();
    bus.i_ren1 = 1; bus.i_raddr1 = 5'd3; bus.i_ren2 = 1; bus.i_raddr2 = 5'd5;
    m_reset();
    #12;
    check("reset.rdata1", bus.o_rdata1, 32'h0);
    check("reset.hi", bus.o_hi, 32'h0);
    check("reset.wb_wen", {31'd0, bus.o_wb_wen}, 32'h0);
    check_all("reset");
    i_rst_n = 1;
    tick("idle");

    // 1: reset mid-write discards the uncommitted entry
    bus.i_wen = 1; bus.i_waddr = 5'd3; bus.i_wdata = 32'hDEADBEEF;
    tick("t1_cap");
    check("t1_wb_wdata", bus.o_wb_wdata, 32'hDEADBEEF);
    i_rst_n = 0; m_reset();
    settle("t1_inrst");
    #2; i_rst_n = 1; idle();
    tick("t1_after");
    check("t1_gpr3", bus.o_rdata1, 32'h0);

    // 2: write, bypass, then from the array
    bus.i_wen = 1; bus.i_waddr = 5'd5; bus.i_wdata = 32'h12345678;
    tick("t2_cap");
    idle(); bus.i_raddr1 = 5'd5;
    settle("t2_byp");
    check("t2_bypass", bus.o_rdata1, 32'h12345678);
    check("t2_wb_wen", {31'd0, bus.o_wb_wen}, 32'h1);
    tick("t2_gpr");
    check("t2_gpr5", bus.o_rdata1, 32'h12345678);

    // 3: r0 stays zero
    bus.i_wen = 1; bus.i_waddr = 5'd0; bus.i_wdata = 32'hFFFFFFFF;
    tick("t3_cap");
    idle(); bus.i_raddr1 = 5'd0;
    settle("t3_byp");
    check("t3_r0_byp", bus.o_rdata1, 32'h0);
    check("t3_wb_wen", {31'd0, bus.o_wb_wen}, 32'h1);
    check("t3_wb_waddr", {27'd0, bus.o_wb_waddr}, 32'h0);
    tick("t3_after");
    check("t3_r0", bus.o_rdata1, 32'h0);

    // 4: HI/LO bypass and commit
    bus.i_hilo_wen = 1; bus.i_hi = 32'hAAAA0000; bus.i_lo = 32'h0000BBBB;
    tick("t4_cap");
    check("t4_hi_byp", bus.o_hi, 32'hAAAA0000);
    check("t4_lo_byp", bus.o_lo, 32'h0000BBBB);
    idle();
    tick("t4_commit");
    tick("t4_hold");
    check("t4_hi", bus.o_hi, 32'hAAAA0000);
    check("t4_lo", bus.o_lo, 32'h0000BBBB);

    // 5: stall holds, flush beats stall but the leaving entry still commits
    bus.i_wen = 1; bus.i_waddr = 5'd7; bus.i_wdata = 32'd1;
    tick("t5_cap");
    bus.i_stall = 1; bus.i_waddr = 5'd8; bus.i_wdata = 32'd2;
    bus.i_raddr2 = 5'd8;
    for (int i = 0; i < 3; i++) begin
      tick("t5_stall");
      check("t5_wb_waddr", {27'd0, bus.o_wb_waddr}, 32'd7);
      check("t5_wb_wdata", bus.o_wb_wdata, 32'd1);
      check("t5_gpr8", bus.o_rdata2, 32'd0);
    end
    bus.i_flush = 1;
    tick("t5_flush");
    idle(); bus.i_raddr1 = 5'd7;
    settle("t5_post");
    check("t5_wb_wen", {31'd0, bus.o_wb_wen}, 32'd0);
    check("t5_gpr7", bus.o_rdata1, 32'd1);
    check("t5_gpr8b", bus.o_rdata2, 32'd0);

    // 6: read enables, dual port, back-to-back writes
    bus.i_ren2 = 0; bus.i_raddr2 = 5'd7;
    settle("t6_ren0");
    check("t6_ren2_off", bus.o_rdata2, 32'd0);
    bus.i_ren2 = 1;
    settle("t6_dual");
    check("t6_dual1", bus.o_rdata1, 32'd1);
    check("t6_dual2", bus.o_rdata2, 32'd1);
    bus.i_wen = 1; bus.i_waddr = 5'd9; bus.i_wdata = 32'd3; bus.i_raddr1 = 5'd9;
    tick("t6_w3");
    check("t6_r9_3", bus.o_rdata1, 32'd3);
    bus.i_wdata = 32'd4;
    tick("t6_w4");
    check("t6_r9_4", bus.o_rdata1, 32'd4);
    idle();
    tick("t6_done");
    check("t6_r9_final", bus.o_rdata1, 32'd4);

    // randomized traffic, small address range favours bypass hits
    for (int n = 0; n < 400; n++) begin
      bus.i_stall    = ($urandom_range(3) == 0);
      bus.i_flush    = ($urandom_range(7) == 0);
      bus.i_wen      = $urandom_range(1);
      bus.i_waddr    = AW'($urandom_range(($urandom_range(3) == 0) ? 31 : 7));
      bus.i_wdata    = $urandom;
      bus.i_hilo_wen = ($urandom_range(3) == 0);
      bus.i_hi       = $urandom;
      bus.i_lo       = $urandom;
      bus.i_ren1     = ($urandom_range(7) != 0);
      bus.i_raddr1   = AW'($urandom_range(7));
      bus.i_ren2     = ($urandom_range(7) != 0);
      bus.i_raddr2   = AW'($urandom_range(31));
      if ($urandom_range(63) == 0) begin
        i_rst_n = 0; m_reset();
        settle("rnd_rst");
        #2; i_rst_n = 1;
      end
      tick("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
